load_unit: RTL and testbench

Multi-cycle load controller for the CPU's memory stage. Accepts one load per handshake, computes the effective address, issues a word-aligned read on a request/grant/valid memory port, and waits for read data. It then extracts the addressed byte or halfword and sign- or zero-extends it per funct3, and returns the result with its destination register. Misaligned and illegal loads are flagged without touching memory.

---
 rtl/load_pkg.sv | 19 +
 rtl/loads_sign_extend.sv | 20 ++
 rtl/load_unit.sv | 112 +++++++++++
 tb/tb_load_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_pkg.sv
// load_pkg: shared load types, funct3 encodings, FSM states and the load fault check.
package load_pkg;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

   // Fault if funct3 is not a load or the address is not naturally aligned for its size
   function automatic logic load_err(input logic [2:0] f3, input logic [1:0] ea_lo);
      return !(f3 inside {LB, LH, LW, LBU, LHU})
          || ((f3 == LH || f3 == LHU) && ea_lo[0])
          || (f3 == LW && ea_lo != 2'b00);
   endfunction

endpackage

// File: rtl/loads_sign_extend.sv
// loads_sign_extend: widens a right-aligned byte/halfword to DATA_WIDTH per load funct3.
module loads_sign_extend
   import load_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic [2:0]            funct3_i,
   output logic [DATA_WIDTH-1:0] data_o
);

   always_comb begin
      data_o = funct3_i == LB  ? {{(DATA_WIDTH-8){data_i[7]}}, data_i[7:0]}
             : funct3_i == LH  ? {{(DATA_WIDTH-16){data_i[15]}}, data_i[15:0]}
             : funct3_i == LBU ? {{(DATA_WIDTH-8){1'b0}}, data_i[7:0]}
             : funct3_i == LHU ? {{(DATA_WIDTH-16){1'b0}}, data_i[15:0]}
             : data_i;
   end

endmodule

// File: rtl/load_unit.sv
// load_unit: multi-cycle load controller; computes the address, reads a word over a
// req/gnt/rvalid port, extracts and extends the addressed byte/halfword.
module load_unit
   import load_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] base,
   input  logic [DATA_WIDTH-1:0] imm,
   input  logic [2:0]            funct3,
   input  logic [4:0]            rd_in,
   output logic                  busy,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  done,
   output logic                  err,
   output logic [DATA_WIDTH-1:0] result,
   output logic [4:0]            rd_out
);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] ea_q, ea_d;
   logic [2:0]            f3_q, f3_d;
   logic [4:0]            rd_q, rd_d, rd_out_q, rd_out_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic [DATA_WIDTH-1:0] sum, shifted, masked, extended;
   logic                  capture;

   assign sum     = base + imm;
   assign shifted = mem_rdata >> {ea_q[1:0], 3'b000};
   assign masked  = f3_q == LBU ? shifted & DATA_WIDTH'(8'hFF)
                  : f3_q == LHU ? shifted & DATA_WIDTH'(16'hFFFF)
                  : shifted;
   assign capture = mem_rvalid && (state_q == S_WAIT || (state_q == S_REQ && mem_gnt));

   loads_sign_extend #(.DATA_WIDTH(DATA_WIDTH)) u_ext (
      .data_i  (masked),
      .funct3_i(f3_q),
      .data_o  (extended)
   );

   always_comb begin
      state_d  = state_q;
      ea_d     = ea_q;
      f3_d     = f3_q;
      rd_d     = rd_q;
      err_d    = err_q;
      result_d = result_q;
      rd_out_d = rd_out_q;
      case (state_q)
         S_IDLE: if (start) begin
            ea_d = sum[ADDR_WIDTH-1:0];
            f3_d = funct3;
            rd_d = rd_in;
            if (load_err(funct3, sum[1:0])) begin
               err_d    = 1'b1;
               result_d = '0;
               rd_out_d = rd_in;
               state_d  = S_DONE;
            end else begin
               state_d = S_REQ;
            end
         end
         S_REQ:   state_d = mem_gnt ? (mem_rvalid ? S_DONE : S_WAIT) : S_REQ;
         S_WAIT:  state_d = mem_rvalid ? S_DONE : S_WAIT;
         default: state_d = S_IDLE;
      endcase
      // Results are registered on entry to DONE so they hold until the next completion
      if (capture) begin
         err_d    = 1'b0;
         result_d = extended;
         rd_out_d = rd_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         ea_q     <= '0;
         f3_q     <= '0;
         rd_q     <= '0;
         err_q    <= 1'b0;
         result_q <= '0;
         rd_out_q <= '0;
      end else begin
         state_q  <= state_d;
         ea_q     <= ea_d;
         f3_q     <= f3_d;
         rd_q     <= rd_d;
         err_q    <= err_d;
         result_q <= result_d;
         rd_out_q <= rd_out_d;
      end
   end

   assign busy     = state_q != S_IDLE;
   assign mem_req  = state_q == S_REQ;
   assign mem_addr = mem_req ? {ea_q[ADDR_WIDTH-1:2], 2'b00} : '0;
   assign done     = state_q == S_DONE;
   assign err      = err_q;
   assign result   = result_q;
   assign rd_out   = rd_out_q;

endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: scenario tasks with a scoreboard of expected load completions.
module tb_load_unit;

   logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [31:0] base = '0, imm = '0;
   logic [2:0]  funct3 = '0;
   logic [4:0]  rd_in = '0;
   logic        busy, mem_req, done, err;
   logic [31:0] mem_addr, result;
   logic [4:0]  rd_out;
   logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;

   load_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .base(base), .imm(imm), .funct3(funct3),
      .rd_in(rd_in), .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .done(done), .err(err), .result(result), .rd_out(rd_out)
   );

   always #5 clk = ~clk;

   typedef struct {logic [31:0] res; logic [4:0] rd; logic err;} exp_t;
   exp_t sb[$];
   int total = 0, passed = 0;

   int          o_done_n, o_req_n;
   logic        o_addr_bad, o_err;
   logic [31:0] o_res;
   logic [4:0]  o_rd;

   function automatic exp_t model(input logic [31:0] b, input logic [31:0] i, input logic [2:0] f,
                                  input logic [4:0] r, input logic [31:0] w);
      logic [31:0] ea;
      logic [7:0]  by;
      logic [15:0] hw;
      exp_t        e;
      ea = b + i;
      by = w[8*ea[1:0] +: 8];
      hw = ea[1] ? w[31:16] : w[15:0];
      e.rd = r;
      e.err = 1'b0;
      e.res = '0;
      case (f)
         3'b000:  e.res = {{24{by[7]}}, by};
         3'b001:  e.res = {{16{hw[15]}}, hw};
         3'b010:  e.res = w;
         3'b100:  e.res = {24'h0, by};
         3'b101:  e.res = {16'h0, hw};
         default: e.err = 1'b1;
      endcase
      if ((f == 3'b001 || f == 3'b101) && ea[0]) e.err = 1'b1;
      if (f == 3'b010 && ea[1:0] != 2'b00) e.err = 1'b1;
      if (e.err) e.res = '0;
      return e;
   endfunction

   // Drives one load and plays memory: grant gd cycles after REQ starts, rvalid vd cycles after grant
   task automatic run_load(input logic [31:0] b, input logic [31:0] i, input logic [2:0] f,
                           input logic [4:0] r, input logic [31:0] w, input int gd, input int vd,
                           input bit noise);
      logic [31:0] wa;
      int gc;
      wa = (b + i) & ~32'h3;
      gc = -1;
      o_done_n = -1; o_req_n = 0; o_addr_bad = 1'b0;
      @(negedge clk);
      start = 1'b1; base = b; imm = i; funct3 = f; rd_in = r;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (done) begin
            o_done_n = n; o_res = result; o_rd = rd_out; o_err = err;
            break;
         end
         if (mem_req) begin
            o_req_n++;
            if (mem_addr !== wa) o_addr_bad = 1'b1;
         end
         mem_gnt = mem_req && (n - 1 >= gd);
         if (mem_gnt) gc = n;
         mem_rvalid = (gc >= 0) && (n == gc + vd);
         mem_rdata = mem_rvalid ? w : $urandom;
         start = noise && busy && ($urandom_range(0, 1) == 1);
         if (start) begin
            base = $urandom; imm = $urandom; funct3 = 3'($urandom); rd_in = 5'($urandom);
         end
      end
      start = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({busy, mem_req, mem_addr, done, err, result, rd_out} !== '0)
         $display("FAIL reset_outputs: busy=%b req=%b addr=%h done=%b err=%b result=%h rd=%0d want all 0",
                  busy, mem_req, mem_addr, done, err, result, rd_out);
      else passed++;
      rst = 1'b0;
   endtask

   task automatic test_lb();
      exp_t e;
      sb.push_back(model(32'h100, 32'd3, 3'b000, 5'd7, 32'h80FF_1234));
      run_load(32'h100, 32'd3, 3'b000, 5'd7, 32'h80FF_1234, 0, 1, 1'b0);
      e = sb.pop_front();
      total++;
      if ({o_res, o_rd, o_err} !== {e.res, e.rd, e.err})
         $display("FAIL lb_result: got %h/%0d/%b want %h/%0d/%b", o_res, o_rd, o_err, e.res, e.rd, e.err);
      else passed++;
      total++;
      if (o_done_n !== 3) $display("FAIL lb_latency: got %0d want 3", o_done_n); else passed++;
      total++;
      if (o_req_n !== 1 || o_addr_bad !== 1'b0)
         $display("FAIL lb_request: req cycles %0d addr_bad %b want 1/0", o_req_n, o_addr_bad);
      else passed++;
   endtask

   task automatic test_half();
      exp_t e;
      for (int k = 0; k < 2; k++) begin
         logic [2:0] f;
         f = k == 0 ? 3'b101 : 3'b001;
         sb.push_back(model(32'h200, 32'd2, f, 5'd12, 32'hBEEF_0000));
         run_load(32'h200, 32'd2, f, 5'd12, 32'hBEEF_0000, 0, 1, 1'b0);
         e = sb.pop_front();
         total++;
         if ({o_res, o_rd, o_err} !== {e.res, e.rd, e.err} || o_done_n !== 3)
            $display("FAIL half_f3_%0d: got %h/%0d/%b at %0d want %h/%0d/%b at 3",
                     f, o_res, o_rd, o_err, o_done_n, e.res, e.rd, e.err);
         else passed++;
      end
   endtask

   task automatic test_err();
      exp_t e;
      for (int k = 0; k < 2; k++) begin
         logic [31:0] i;
         logic [2:0]  f;
         i = k == 0 ? 32'd5 : 32'd0;
         f = k == 0 ? 3'b010 : 3'b011;
         sb.push_back(model(32'h100, i, f, 5'd3, 32'h1234_5678));
         run_load(32'h100, i, f, 5'd3, 32'h1234_5678, 0, 1, 1'b0);
         e = sb.pop_front();
         total++;
         if ({o_res, o_rd, o_err} !== {e.res, e.rd, e.err})
            $display("FAIL err_result_%0d: got %h/%0d/%b want %h/%0d/%b", k, o_res, o_rd, o_err, e.res, e.rd, e.err);
         else passed++;
         total++;
         if (o_done_n !== 1 || o_req_n !== 0)
            $display("FAIL err_timing_%0d: done at %0d req cycles %0d want 1/0", k, o_done_n, o_req_n);
         else passed++;
      end
   endtask

   task automatic test_stall();
      exp_t e;
      sb.push_back(model(32'h3F0, 32'h12, 3'b101, 5'd21, 32'h1234_5678));
      run_load(32'h3F0, 32'h12, 3'b101, 5'd21, 32'h1234_5678, 4, 3, 1'b1);
      e = sb.pop_front();
      total++;
      if ({o_res, o_rd, o_err} !== {e.res, e.rd, e.err})
         $display("FAIL stall_result: got %h/%0d/%b want %h/%0d/%b", o_res, o_rd, o_err, e.res, e.rd, e.err);
      else passed++;
      total++;
      if (o_done_n !== 9 || o_req_n !== 5 || o_addr_bad !== 1'b0)
         $display("FAIL stall_timing: done %0d req %0d addr_bad %b want 9/5/0", o_done_n, o_req_n, o_addr_bad);
      else passed++;
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0)
         $display("FAIL stall_single_done: done=%b busy=%b want 0/0", done, busy);
      else passed++;
   endtask

   task automatic test_same_cycle();
      exp_t e;
      sb.push_back(model(32'h10, 32'd1, 3'b000, 5'd30, 32'h0000_7F00));
      run_load(32'h10, 32'd1, 3'b000, 5'd30, 32'h0000_7F00, 0, 0, 1'b0);
      e = sb.pop_front();
      total++;
      if ({o_res, o_rd, o_err} !== {e.res, e.rd, e.err} || o_done_n !== 2)
         $display("FAIL same_cycle: got %h/%0d/%b at %0d want %h/%0d/%b at 2",
                  o_res, o_rd, o_err, o_done_n, e.res, e.rd, e.err);
      else passed++;
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int   spurious;
      spurious = 0;
      @(negedge clk);
      start = 1'b1; base = 32'h40; imm = 32'h0; funct3 = 3'b010; rd_in = 5'd9;
      @(negedge clk);
      start = 1'b0; mem_gnt = mem_req;
      @(negedge clk);
      mem_gnt = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      total++;
      if ({busy, mem_req, mem_addr, done, err, result, rd_out} !== '0)
         $display("FAIL midreset_outputs: busy=%b req=%b addr=%h done=%b err=%b result=%h rd=%0d want all 0",
                  busy, mem_req, mem_addr, done, err, result, rd_out);
      else passed++;
      repeat (3) begin
         @(negedge clk);
         mem_rvalid = 1'b0;
         if (done !== 1'b0 || busy !== 1'b0) spurious++;
      end
      total++;
      if (spurious !== 0) $display("FAIL midreset_dropped: %0d cycles with done/busy want 0", spurious);
      else passed++;
      sb.push_back(model(32'h40, 32'h0, 3'b010, 5'd9, 32'hCAFE_F00D));
      run_load(32'h40, 32'h0, 3'b010, 5'd9, 32'hCAFE_F00D, 1, 2, 1'b0);
      e = sb.pop_front();
      total++;
      if ({o_res, o_rd, o_err} !== {e.res, e.rd, e.err} || o_done_n !== 5)
         $display("FAIL midreset_recover: got %h/%0d/%b at %0d want %h/%0d/%b at 5",
                  o_res, o_rd, o_err, o_done_n, e.res, e.rd, e.err);
      else passed++;
   endtask

   task automatic test_back_to_back();
      exp_t e;
      sb.push_back(model(32'h500, 32'd1, 3'b100, 5'd1, 32'h0000_AB00));
      sb.push_back(model(32'h4FF, 32'd1, 3'b001, 5'd2, 32'h0000_8001));
      run_load(32'h500, 32'd1, 3'b100, 5'd1, 32'h0000_AB00, 0, 1, 1'b0);
      e = sb.pop_front();
      total++;
      if ({o_res, o_rd, o_err} !== {e.res, e.rd, e.err} || o_done_n !== 3)
         $display("FAIL b2b_first: got %h/%0d/%b at %0d want %h/%0d/%b at 3",
                  o_res, o_rd, o_err, o_done_n, e.res, e.rd, e.err);
      else passed++;
      run_load(32'h4FF, 32'd1, 3'b001, 5'd2, 32'h0000_8001, 0, 1, 1'b0);
      e = sb.pop_front();
      total++;
      if ({o_res, o_rd, o_err} !== {e.res, e.rd, e.err} || o_done_n !== 3)
         $display("FAIL b2b_second: got %h/%0d/%b at %0d want %h/%0d/%b at 3",
                  o_res, o_rd, o_err, o_done_n, e.res, e.rd, e.err);
      else passed++;
      @(negedge clk);
      total++;
      if (result !== e.res || rd_out !== e.rd)
         $display("FAIL b2b_hold: result %h rd %0d want %h/%0d", result, rd_out, e.res, e.rd);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_lb();
      test_half();
      test_err();
      test_stall();
      test_same_cycle();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
